// File: rtl/tx_source_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tx_source_sequencer
// Description : Registered, glitch-free selector for the TX lane source ahead
//               of CorePCS. A source change is held until the active source
//               emits an idle comma word (or a timeout expires). A run of
//               guard idle words is then inserted before the new source is
//               handed the lane. Forced (timeout) switches are counted.
//
// Parameters  : GUARD_WORDS  idle words inserted between sources (1..16)
//               TIMEOUT      cycles to wait for a boundary (2..65535)
//               IDLE_DATA    idle/comma word data (K28.5 in the low byte)
//               IDLE_KCHAR   K-flags of the idle word
//
// Ports       : TX_CLK                     TX word clock (only clock)
//               RESET_N                    async assert, active-low reset
//               PRBS_EN / DTCSIM_EN        source requests (PRBS wins)
//               PRBS_DATA/PRBS_KCHAR       PRBS generator word
//               DTCSIM_DATA/DTCSIM_KCHAR   DTC emulator word
//               FIBER_DATA/FIBER_KCHAR     TxPacketWriter word
//               TX_DATA/TX_KCHAR           registered word to CorePCS
//               SEL                        active source 0=fiber 1=DTC 2=PRBS
//               SWITCH_BUSY                high while a switch is in progress
//               FORCED_CNT                 saturating forced-switch count
//
// Revision    : 1.0  initial release
// ============================================================================
module tx_source_sequencer #(
    parameter int unsigned GUARD_WORDS = 4,
    parameter int unsigned TIMEOUT     = 1024,
    parameter logic [15:0] IDLE_DATA   = 16'h50BC,
    parameter logic [1:0]  IDLE_KCHAR  = 2'b01
) (
    input  logic        TX_CLK,
    input  logic        RESET_N,
    input  logic        PRBS_EN,
    input  logic        DTCSIM_EN,
    input  logic [15:0] PRBS_DATA,
    input  logic [1:0]  PRBS_KCHAR,
    input  logic [15:0] DTCSIM_DATA,
    input  logic [1:0]  DTCSIM_KCHAR,
    input  logic [15:0] FIBER_DATA,
    input  logic [1:0]  FIBER_KCHAR,
    output logic [15:0] TX_DATA,
    output logic [1:0]  TX_KCHAR,
    output logic [1:0]  SEL,
    output logic        SWITCH_BUSY,
    output logic [7:0]  FORCED_CNT
);

    // Last value of the timeout counter before a switch is forced, and the
    // guard counter load value (counts down to 0 inclusive).
    localparam logic [15:0] c_TOUT_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  c_GUARD_LOAD = 4'(GUARD_WORDS - 1);

    localparam logic [1:0] c_SEL_FIBER = 2'd0;
    localparam logic [1:0] c_SEL_DTC   = 2'd1;
    localparam logic [1:0] c_SEL_PRBS  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  sel_q;
    logic [15:0] tx_data_q;
    logic [1:0]  tx_kchar_q;
    logic        busy_q;
    logic [7:0]  forced_q;
    logic [15:0] tout_q;
    logic [3:0]  guard_q;

    logic [1:0]  req_sel;
    logic [15:0] src_data;
    logic [1:0]  src_kchar;
    logic        boundary;

    // Requested source, fixed priority PRBS > DTC emulator > fiber.
    always_comb begin
        req_sel = c_SEL_FIBER;
        if (PRBS_EN) begin
            req_sel = c_SEL_PRBS;
        end else if (DTCSIM_EN) begin
            req_sel = c_SEL_DTC;
        end
    end

    // Word from the currently active source. SEL never holds 3; the default
    // falls back to fiber so the mux is fully specified.
    always_comb begin
        src_data  = FIBER_DATA;
        src_kchar = FIBER_KCHAR;
        case (sel_q)
            c_SEL_DTC: begin
                src_data  = DTCSIM_DATA;
                src_kchar = DTCSIM_KCHAR;
            end
            c_SEL_PRBS: begin
                src_data  = PRBS_DATA;
                src_kchar = PRBS_KCHAR;
            end
            default: begin
            end
        endcase
    end

    // A safe switch point: the active source is sending an idle comma.
    assign boundary = (src_kchar == IDLE_KCHAR) &&
                      (src_data[7:0] == IDLE_DATA[7:0]);

    // Single-process FSM; every output comes straight from a flop.
    // Deassertion of RESET_N is expected to be synchronous to TX_CLK.
    always_ff @(posedge TX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_RUN;
            sel_q      <= c_SEL_FIBER;
            tx_data_q  <= IDLE_DATA;
            tx_kchar_q <= IDLE_KCHAR;
            busy_q     <= 1'b0;
            forced_q   <= 8'd0;
            tout_q     <= 16'd0;
            guard_q    <= 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    tx_data_q  <= src_data;
                    tx_kchar_q <= src_kchar;
                    if (req_sel != sel_q) begin
                        state_q <= ST_WAIT;
                        tout_q  <= 16'd0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    // The current source keeps the lane; a boundary word itself
                    // is passed through before the guard run starts.
                    tx_data_q  <= src_data;
                    tx_kchar_q <= src_kchar;
                    if (req_sel == sel_q) begin
                        // Request withdrawn: abandon the switch without guards.
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else if (boundary) begin
                        state_q <= ST_GUARD;
                        guard_q <= c_GUARD_LOAD;
                    end else if (tout_q == c_TOUT_LAST) begin
                        state_q <= ST_GUARD;
                        guard_q <= c_GUARD_LOAD;
                        if (forced_q != 8'hFF) begin
                            forced_q <= forced_q + 8'd1;
                        end
                    end else begin
                        tout_q <= tout_q + 16'd1;
                    end
                end

                ST_GUARD: begin
                    tx_data_q  <= IDLE_DATA;
                    tx_kchar_q <= IDLE_KCHAR;
                    if (guard_q == 4'd0) begin
                        // Latest request wins, even if it is the old source.
                        sel_q   <= req_sel;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        guard_q <= guard_q - 4'd1;
                    end
                end

                default: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_DATA     = tx_data_q;
    assign TX_KCHAR    = tx_kchar_q;
    assign SEL         = sel_q;
    assign SWITCH_BUSY = busy_q;
    assign FORCED_CNT  = forced_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_source_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_source_sequencer
// Description : Directed self-checking bench for tx_source_sequencer with
//               GUARD_WORDS=4 and TIMEOUT=16. Inputs change 1 ns after the
//               rising edge; outputs are sampled at that same point.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tx_source_sequencer;

    localparam logic [15:0] c_IDLE  = 16'h50BC;
    localparam logic [1:0]  c_IDLEK = 2'b01;
    localparam logic [15:0] c_DTC   = 16'hAAAA;
    localparam logic [15:0] c_PRBS  = 16'h5A5A;
    localparam logic [15:0] c_FIB   = 16'h1234;

    logic        TX_CLK = 1'b0;
    logic        RESET_N;
    logic        PRBS_EN;
    logic        DTCSIM_EN;
    logic [15:0] PRBS_DATA;
    logic [1:0]  PRBS_KCHAR;
    logic [15:0] DTCSIM_DATA;
    logic [1:0]  DTCSIM_KCHAR;
    logic [15:0] FIBER_DATA;
    logic [1:0]  FIBER_KCHAR;
    logic [15:0] TX_DATA;
    logic [1:0]  TX_KCHAR;
    logic [1:0]  SEL;
    logic        SWITCH_BUSY;
    logic [7:0]  FORCED_CNT;

    int n_checks = 0;
    int n_errors = 0;

    tx_source_sequencer #(
        .GUARD_WORDS (4),
        .TIMEOUT     (16),
        .IDLE_DATA   (16'h50BC),
        .IDLE_KCHAR  (2'b01)
    ) dut (
        .TX_CLK       (TX_CLK),
        .RESET_N      (RESET_N),
        .PRBS_EN      (PRBS_EN),
        .DTCSIM_EN    (DTCSIM_EN),
        .PRBS_DATA    (PRBS_DATA),
        .PRBS_KCHAR   (PRBS_KCHAR),
        .DTCSIM_DATA  (DTCSIM_DATA),
        .DTCSIM_KCHAR (DTCSIM_KCHAR),
        .FIBER_DATA   (FIBER_DATA),
        .FIBER_KCHAR  (FIBER_KCHAR),
        .TX_DATA      (TX_DATA),
        .TX_KCHAR     (TX_KCHAR),
        .SEL          (SEL),
        .SWITCH_BUSY  (SWITCH_BUSY),
        .FORCED_CNT   (FORCED_CNT)
    );

    always #5 TX_CLK = ~TX_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge TX_CLK);
        #1;
    endtask

    // Advance until the switch in progress completes (bounded).
    task automatic wait_switch_done(input string tag);
        int n;
        n = 0;
        while (SWITCH_BUSY && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk(tag, {31'd0, SWITCH_BUSY}, 32'd0);
    endtask

    // Expected sequence for the boundary-driven fiber -> DTC switch.
    logic [15:0] t2_fib  [9];
    logic [1:0]  t2_fibk [9];
    logic [15:0] t2_tx   [9];
    logic [1:0]  t2_txk  [9];
    logic [1:0]  t2_sel  [9];
    logic        t2_busy [9];

    initial begin
        t2_fib  = '{16'h1111, 16'h2222, 16'h3333, 16'h00BC, c_FIB, c_FIB, c_FIB, c_FIB, c_FIB};
        t2_fibk = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        t2_tx   = '{16'h1111, 16'h2222, 16'h3333, 16'h00BC, c_IDLE, c_IDLE, c_IDLE, c_IDLE, c_DTC};
        t2_txk  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        t2_sel  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        t2_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_tx;
        logic [1:0]  exp_k;
        logic [1:0]  exp_sel;
        logic        exp_busy;
        int          n;

        // ---------------- reset with fiber streaming ----------------
        RESET_N      = 1'b0;
        PRBS_EN      = 1'b0;
        DTCSIM_EN    = 1'b0;
        PRBS_DATA    = c_PRBS;
        PRBS_KCHAR   = 2'b00;
        DTCSIM_DATA  = c_DTC;
        DTCSIM_KCHAR = 2'b00;
        FIBER_DATA   = c_FIB;
        FIBER_KCHAR  = 2'b00;
        repeat (3) tick();
        chk("rst_data",   TX_DATA, c_IDLE);
        chk("rst_kchar",  TX_KCHAR, c_IDLEK);
        chk("rst_sel",    SEL, 2'd0);
        chk("rst_busy",   SWITCH_BUSY, 1'b0);
        chk("rst_forced", FORCED_CNT, 8'd0);
        RESET_N = 1'b1;
        tick();
        tick();
        chk("rel_data",  TX_DATA, c_FIB);
        chk("rel_kchar", TX_KCHAR, 2'b00);
        chk("rel_sel",   SEL, 2'd0);

        // ---------------- fiber -> DTC on a boundary word ----------------
        DTCSIM_EN = 1'b1;
        for (int i = 0; i < 9; i++) begin
            FIBER_DATA  = t2_fib[i];
            FIBER_KCHAR = t2_fibk[i];
            tick();
            chk($sformatf("bnd_data[%0d]", i), TX_DATA, t2_tx[i]);
            chk($sformatf("bnd_k[%0d]", i),    TX_KCHAR, t2_txk[i]);
            chk($sformatf("bnd_sel[%0d]", i),  SEL, t2_sel[i]);
            chk($sformatf("bnd_busy[%0d]", i), SWITCH_BUSY, t2_busy[i]);
        end
        chk("bnd_forced", FORCED_CNT, 8'd0);

        // ---------------- DTC -> PRBS by timeout ----------------
        PRBS_EN = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            if (k <= 16) begin
                exp_tx = c_DTC;  exp_k = 2'b00; exp_sel = 2'd1; exp_busy = 1'b1;
            end else if (k <= 20) begin
                exp_tx = c_IDLE; exp_k = c_IDLEK;
                exp_sel  = (k == 20) ? 2'd2 : 2'd1;
                exp_busy = (k != 20);
            end else begin
                exp_tx = c_PRBS; exp_k = 2'b00; exp_sel = 2'd2; exp_busy = 1'b0;
            end
            chk($sformatf("to_data[%0d]", k), TX_DATA, exp_tx);
            chk($sformatf("to_k[%0d]", k),    TX_KCHAR, exp_k);
            chk($sformatf("to_sel[%0d]", k),  SEL, exp_sel);
            chk($sformatf("to_busy[%0d]", k), SWITCH_BUSY, exp_busy);
            if (k == 15 || k == 16) begin
                chk($sformatf("to_forced[%0d]", k), FORCED_CNT, (k == 16) ? 8'd1 : 8'd0);
            end
        end
        chk("to_forced_end", FORCED_CNT, 8'd1);

        // ---------------- back to fiber via a PRBS boundary ----------------
        PRBS_EN    = 1'b0;
        DTCSIM_EN  = 1'b0;
        PRBS_DATA  = 16'h00BC;
        PRBS_KCHAR = 2'b01;
        n = 0;
        while (SEL != 2'd0 && n < 50) begin
            tick();
            n++;
        end
        chk("ret_sel",    SEL, 2'd0);
        chk("ret_forced", FORCED_CNT, 8'd1);
        PRBS_DATA  = c_PRBS;
        PRBS_KCHAR = 2'b00;
        tick();
        chk("ret_data", TX_DATA, c_FIB);

        // ---------------- 3-cycle DTC pulse, no boundary ----------------
        for (int p = 0; p < 6; p++) begin
            DTCSIM_EN = (p < 3);
            tick();
            chk($sformatf("pulse_busy[%0d]", p), SWITCH_BUSY, (p < 3));
            chk($sformatf("pulse_data[%0d]", p), TX_DATA, c_FIB);
            chk($sformatf("pulse_sel[%0d]", p),  SEL, 2'd0);
        end
        chk("pulse_forced", FORCED_CNT, 8'd1);

        // ---------------- 260 forced switches, saturation ----------------
        for (int s = 0; s < 260; s++) begin
            DTCSIM_EN = ~DTCSIM_EN;
            tick();
            wait_switch_done($sformatf("sat_bound[%0d]", s));
            if (s == 9) chk("sat_forced_10", FORCED_CNT, 8'd11);
            if (s == 9) chk("sat_sel_10", SEL, 2'd0);
            if (s == 10) chk("sat_sel_11", SEL, 2'd1);
        end
        chk("sat_forced", FORCED_CNT, 8'd255);
        chk("sat_sel",    SEL, 2'd0);

        // ---------------- reset during the second guard word ----------------
        DTCSIM_EN   = 1'b1;
        FIBER_DATA  = 16'h00BC;
        FIBER_KCHAR = 2'b01;
        tick();                          // RUN -> WAIT
        tick();                          // boundary -> GUARD
        chk("rg_bnd", TX_DATA, 16'h00BC);
        FIBER_DATA  = c_FIB;
        FIBER_KCHAR = 2'b00;
        tick();                          // first guard word
        tick();                          // second guard word
        chk("rg_guard2", TX_DATA, c_IDLE);
        chk("rg_busy_pre", SWITCH_BUSY, 1'b1);
        RESET_N   = 1'b0;
        DTCSIM_EN = 1'b0;
        #1;
        chk("rg_data",   TX_DATA, c_IDLE);
        chk("rg_kchar",  TX_KCHAR, c_IDLEK);
        chk("rg_busy",   SWITCH_BUSY, 1'b0);
        chk("rg_forced", FORCED_CNT, 8'd0);
        chk("rg_sel",    SEL, 2'd0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        tick();
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("rg_resume_data[%0d]", r), TX_DATA, c_FIB);
            chk($sformatf("rg_resume_busy[%0d]", r), SWITCH_BUSY, 1'b0);
            tick();
        end
        chk("rg_resume_sel", SEL, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
